// File: rtl/freq_disp_pkg.sv
// Shared types and constants for the frequency display front end:
// the binary-to-BCD converter state type, BCD digit type and range limits.
package freq_disp_pkg;

  // Binary input width (frequency in milli-hertz).
  localparam int BIN_W = 24;

  // Internal BCD digit count (d6..d0).
  localparam int N_BCD = 7;

  // Number of digits shown on the display.
  localparam int N_DISP = 4;

  // Largest representable input: 9999.999 Hz expressed in mHz.
  localparam logic [BIN_W-1:0] MAX_VAL = 24'd9_999_999;

  // One BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    CONV,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decimal digit.
module bcd_adj3
  import freq_disp_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  // Add 3 whenever the digit would reach 10 or more after doubling.
  always_comb begin
    adjusted = digit;
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end
  end

endmodule

// File: rtl/freq_bcd_autoscale.sv
// Iterative binary-to-BCD converter with decimal autoscaling for the
// low-frequency counter display. Converts a mHz value into seven BCD digits,
// then shifts leading zeros out (at most three times) so the four displayed
// digits carry the most significant information, and reports where the
// decimal point lands as a one-hot vector.
module freq_bcd_autoscale
  import freq_disp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic              ready,
  output logic              done_tick,
  output bcd_digit_t        bcd_out [N_DISP-1:0],
  output logic [N_DISP-1:0] autoscale,
  output logic              overflow
);

  localparam int BCD_W     = N_BCD * 4;
  localparam int MAX_SHIFT = N_BCD - N_DISP;
  localparam int CNT_W     = $clog2(BIN_W);
  localparam int SHIFT_W   = 2;

  state_t             state;
  state_t             state_next;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_reg;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SHIFT_W-1:0] shift_cnt;
  logic               over_range;
  logic               norm_shift;

  // Per-digit add-3 correction applied to the BCD register every CONV cycle.
  for (genvar g = 0; g < N_BCD; g++) begin : g_adj
    bcd_adj3 u_adj (
      .digit   (bcd_reg[g*4 +: 4]),
      .adjusted(bcd_adj[g*4 +: 4])
    );
  end

  // Range check on the incoming value and the normalisation decision.
  always_comb begin
    over_range = 1'b0;
    norm_shift = 1'b0;
    over_range = (bin > MAX_VAL);
    norm_shift = (bcd_reg[BCD_W-1 -: 4] == 4'd0) &&
                 (shift_cnt < SHIFT_W'(MAX_SHIFT));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state sequencing and status outputs derived from the state.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done_tick  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = over_range ? DONE : CONV;
        end
      end
      CONV: begin
        if (bit_cnt == '0) begin
          state_next = NORM;
        end
      end
      NORM: begin
        if (!norm_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done_tick  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load, double-dabble shifting, digit normalisation and the
  // registered result, which is written only on the way into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_sr    <= '0;
      bcd_reg   <= '0;
      bit_cnt   <= '0;
      shift_cnt <= '0;
      for (int i = 0; i < N_DISP; i++) begin
        bcd_out[i] <= 4'd0;
      end
      autoscale <= N_DISP'(1);
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr    <= bin;
            bcd_reg   <= '0;
            shift_cnt <= '0;
            bit_cnt   <= CNT_W'(BIN_W - 1);
            if (over_range) begin
              for (int i = 0; i < N_DISP; i++) begin
                bcd_out[i] <= 4'd9;
              end
              autoscale <= N_DISP'(1);
              overflow  <= 1'b1;
            end
          end
        end
        CONV: begin
          {bcd_reg, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          bit_cnt           <= bit_cnt - 1'b1;
        end
        NORM: begin
          if (norm_shift) begin
            bcd_reg   <= {bcd_reg[BCD_W-5:0], 4'd0};
            shift_cnt <= shift_cnt + 1'b1;
          end else begin
            for (int i = 0; i < N_DISP; i++) begin
              bcd_out[i] <= bcd_reg[(MAX_SHIFT + i)*4 +: 4];
            end
            autoscale <= N_DISP'(1) << shift_cnt;
            overflow  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
